fpu_issue_seq: RTL and testbench

//  In-order issue/completion sequencer for the FPU. Replaces the fixed per-op fpu_stall pipeline freeze.
//  - Accepts FP ops (5-bit fpu_cont code + dest tag) by valid/ready; up to DEPTH ops in flight.
//  - Per-op latency is parameterised. Each result is captured from the shared FPU result bus exactly when due.
//  - Results return to writeback in program order. Same-cycle completion collisions are blocked at issue.

---
 rtl/fpu_issue_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_fpu_issue_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_seq.sv
// In-order issue/completion sequencer for the FPU: tracks up to DEPTH ops, captures fu_y when due, retires in order.
// Optional FPU_SEQ_PERF_EN adds saturating stall_cyc/busy_cyc performance counters.
module fpu_issue_seq #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 5,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 4,
    parameter int LAT_FADD  = 4,
    parameter int LAT_FMUL  = 4,
    parameter int LAT_FDIV  = 6,
    parameter int LAT_FSQRT = 2,
    parameter int LAT_FCVT  = 1,
    parameter int LAT_MISC  = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic [4:0]        fu_sel,
    input  logic [DATA_W-1:0] fu_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [TAG_W-1:0]  res_tag,
    output logic [DATA_W-1:0] res_data,
    output logic [4:0]        res_op
`ifdef FPU_SEQ_PERF_EN
    ,
    output logic [31:0]       stall_cyc,
    output logic [31:0]       busy_cyc
`endif
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_Q_W = $clog2(DEPTH + 1);

    function automatic logic [CNT_W-1:0] f_lat(input logic [4:0] op);
        case (op)
            5'b10000, 5'b10001: f_lat = CNT_W'(LAT_FADD);
            5'b10010:           f_lat = CNT_W'(LAT_FMUL);
            5'b10011:           f_lat = CNT_W'(LAT_FDIV);
            5'b10100:           f_lat = CNT_W'(LAT_FSQRT);
            5'b11100, 5'b11101: f_lat = CNT_W'(LAT_FCVT);
            default:            f_lat = CNT_W'(LAT_MISC);
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        f_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic              r_valid [DEPTH];
    logic              r_done  [DEPTH];
    logic [4:0]        r_op    [DEPTH];
    logic [TAG_W-1:0]  r_tag   [DEPTH];
    logic [CNT_W-1:0]  r_cnt   [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];

    logic              w_valid_next [DEPTH];
    logic              w_done_next  [DEPTH];
    logic [4:0]        w_op_next    [DEPTH];
    logic [TAG_W-1:0]  w_tag_next   [DEPTH];
    logic [CNT_W-1:0]  w_cnt_next   [DEPTH];
    logic [DATA_W-1:0] w_data_next  [DEPTH];

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_Q_W-1:0] r_count;

    logic              r_res_valid;
    logic [TAG_W-1:0]  r_res_tag;
    logic [DATA_W-1:0] r_res_data;
    logic [4:0]        r_res_op;

    logic [DEPTH-1:0]  w_pend;
    logic [DEPTH-1:0]  w_hit0;
    logic [DEPTH-1:0]  w_coll;
    logic [CNT_W-1:0]  w_lat_new;
    logic [CNT_W-1:0]  w_cnt_init;
    logic              w_full;
    logic              w_issue;
    logic              w_pop;
    logic              w_cmp_hit;
    logic [PTR_W-1:0]  w_cmp_idx;
    logic [PTR_W-1:0]  w_next_rd;

    assign w_lat_new  = f_lat(in_op);
    assign w_cnt_init = (w_lat_new == '0) ? '0 : w_lat_new - 1'b1;

    // A pending entry with cnt==c completes c cycles from now; a new op completes L cycles from now.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign w_pend[gi] = r_valid[gi] && !r_done[gi];
            assign w_hit0[gi] = w_pend[gi] && (r_cnt[gi] == '0);
            assign w_coll[gi] = w_pend[gi] && (r_cnt[gi] == w_lat_new);
        end
    endgenerate

    always_comb begin
        w_cmp_hit = 1'b0;
        w_cmp_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_hit0[i]) begin
                w_cmp_hit = 1'b1;
                w_cmp_idx = PTR_W'(i);
            end
        end
    end

    assign w_full    = (r_count == CNT_Q_W'(DEPTH));
    assign in_ready  = rstn && !flush && !w_full && !(|w_coll);
    assign w_issue   = in_valid && in_ready;
    assign w_pop     = r_res_valid && res_ready;
    assign w_next_rd = w_pop ? f_inc(r_rd_ptr) : r_rd_ptr;

    // A completion during a flush cycle is discarded, so the FPU mux is left idle.
    always_comb begin
        fu_sel = 5'b0;
        if (!flush) begin
            if (w_cmp_hit) begin
                fu_sel = r_op[w_cmp_idx];
            end else if (w_issue && (w_lat_new == '0)) begin
                fu_sel = in_op;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_next[i] = r_valid[i];
            w_done_next[i]  = r_done[i];
            w_op_next[i]    = r_op[i];
            w_tag_next[i]   = r_tag[i];
            w_cnt_next[i]   = r_cnt[i];
            w_data_next[i]  = r_data[i];
            if (w_pend[i]) begin
                if (r_cnt[i] == '0) begin
                    w_done_next[i] = 1'b1;
                    w_data_next[i] = fu_y;
                end else begin
                    w_cnt_next[i] = r_cnt[i] - 1'b1;
                end
            end
            if (w_pop && (r_rd_ptr == PTR_W'(i))) begin
                w_valid_next[i] = 1'b0;
                w_done_next[i]  = 1'b0;
            end
            if (w_issue && (r_wr_ptr == PTR_W'(i))) begin
                w_valid_next[i] = 1'b1;
                w_op_next[i]    = in_op;
                w_tag_next[i]   = in_tag;
                w_cnt_next[i]   = w_cnt_init;
                w_done_next[i]  = (w_lat_new == '0);
                w_data_next[i]  = (w_lat_new == '0) ? fu_y : '0;
            end
            if (flush) begin
                w_valid_next[i] = 1'b0;
                w_done_next[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_done[i]  <= 1'b0;
                r_op[i]    <= '0;
                r_tag[i]   <= '0;
                r_cnt[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= w_valid_next[i];
                r_done[i]  <= w_done_next[i];
                r_op[i]    <= w_op_next[i];
                r_tag[i]   <= w_tag_next[i];
                r_cnt[i]   <= w_cnt_next[i];
                r_data[i]  <= w_data_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_issue) r_wr_ptr <= f_inc(r_wr_ptr);
            r_rd_ptr <= w_next_rd;
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Result registers look at the post-update head so back-to-back pops need no bubble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_data  <= '0;
            r_res_op    <= '0;
        end else if (flush) begin
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_data  <= '0;
            r_res_op    <= '0;
        end else begin
            r_res_valid <= w_valid_next[w_next_rd] && w_done_next[w_next_rd];
            if (w_valid_next[w_next_rd] && w_done_next[w_next_rd]) begin
                r_res_tag  <= w_tag_next[w_next_rd];
                r_res_data <= w_data_next[w_next_rd];
                r_res_op   <= w_op_next[w_next_rd];
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_tag   = r_res_tag;
    assign res_data  = r_res_data;
    assign res_op    = r_res_op;

`ifdef FPU_SEQ_PERF_EN
    logic [31:0] r_stall_cyc;
    logic [31:0] r_busy_cyc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cyc <= '0;
            r_busy_cyc  <= '0;
        end else begin
            if (in_valid && !in_ready && (r_stall_cyc != '1)) r_stall_cyc <= r_stall_cyc + 1'b1;
            if ((r_count != '0) && (r_busy_cyc != '1))         r_busy_cyc  <= r_busy_cyc + 1'b1;
        end
    end

    assign stall_cyc = r_stall_cyc;
    assign busy_cyc  = r_busy_cyc;
`endif

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Scoreboard bench for fpu_issue_seq: a timing model predicts in_ready, fu_sel and the in-order result stream.
module tb_fpu_issue_seq;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        in_op = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              flush = 1'b0;
    logic [4:0]        fu_sel;
    logic [DATA_W-1:0] fu_y = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [TAG_W-1:0]  res_tag;
    logic [DATA_W-1:0] res_data;
    logic [4:0]        res_op;
`ifdef FPU_SEQ_PERF_EN
    logic [31:0]       stall_cyc;
    logic [31:0]       busy_cyc;
`endif

    fpu_issue_seq #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .flush     (flush),
        .fu_sel    (fu_sel),
        .fu_y      (fu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_tag   (res_tag),
        .res_data  (res_data),
        .res_op    (res_op)
`ifdef FPU_SEQ_PERF_EN
        ,
        .stall_cyc (stall_cyc),
        .busy_cyc  (busy_cyc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [4:0]        op;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t       sb[$];
    logic       sched_v  [64];
    logic [4:0] sched_op [64];
    int         cyc;
    int         n_tests = 0;
    int         n_fail  = 0;

    localparam logic [4:0] OP_FADD  = 5'b10000;
    localparam logic [4:0] OP_FSUB  = 5'b10001;
    localparam logic [4:0] OP_FMUL  = 5'b10010;
    localparam logic [4:0] OP_FDIV  = 5'b10011;
    localparam logic [4:0] OP_FSQRT = 5'b10100;
    localparam logic [4:0] OP_FCVTS = 5'b11100;
    localparam logic [4:0] OP_FCVTW = 5'b11101;
    localparam logic [4:0] OP_FSGNJ = 5'b00110;

    function automatic int lat_of(input logic [4:0] op);
        case (op)
            OP_FADD, OP_FSUB:   return 4;
            OP_FMUL:            return 4;
            OP_FDIV:            return 6;
            OP_FSQRT:           return 2;
            OP_FCVTS, OP_FCVTW: return 1;
            default:            return 0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] fy(input int c);
        return 32'h5A00_0000 ^ (32'(c) * 32'h0001_9E37);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        for (int i = 0; i < 64; i++) sched_v[i] = 1'b0;
    endtask

    task automatic step(input logic v, input logic [4:0] op, input logic [TAG_W-1:0] tg,
                        input logic fl, input logic rr, output logic acc);
        int         lat;
        int         s;
        logic       exp_rdy;
        logic       exp_rv;
        logic       iss;
        logic       pop;
        logic [4:0] exp_fu;
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_tag    = tg;
        flush     = fl;
        res_ready = rr;
        fu_y      = fy(cyc);
        #1;
        lat = lat_of(op);
        s   = cyc % 64;
        exp_rdy = !fl && (sb.size() < DEPTH) && !sched_v[(cyc + lat) % 64];
        check("in_ready", in_ready, exp_rdy);
        iss = v && in_ready;
        if (fl)                    exp_fu = 5'b0;
        else if (sched_v[s])       exp_fu = sched_op[s];
        else if (iss && lat == 0)  exp_fu = op;
        else                       exp_fu = 5'b0;
        check("fu_sel", fu_sel, exp_fu);
        exp_rv = (sb.size() > 0) && (sb[0].due < cyc);
        check("res_valid", res_valid, exp_rv);
        if (exp_rv && res_valid) begin
            check("res_tag", res_tag, sb[0].tag);
            check("res_data", res_data, sb[0].data);
            check("res_op", res_op, sb[0].op);
        end
        pop = res_valid && rr;
        if (fl) begin
            $display("[TB] cyc %0d flush, %0d ops discarded", cyc, sb.size());
            model_clear();
        end else begin
            if (pop && sb.size() > 0) begin
                $display("[TB] cyc %0d retire tag %0d op %b data %h", cyc, res_tag, res_op, res_data);
                void'(sb.pop_front());
            end
            if (iss) begin
                $display("[TB] cyc %0d issue tag %0d op %b lat %0d", cyc, tg, op, lat);
                sb.push_back('{tag: tg, op: op, data: fy(cyc + lat), due: cyc + lat});
                if (lat > 0) begin
                    sched_v[(cyc + lat) % 64]  = 1'b1;
                    sched_op[(cyc + lat) % 64] = op;
                end
            end
        end
        sched_v[s] = 1'b0;
        acc = iss;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 5'b0, '0, 1'b0, rr, acc);
    endtask

    task automatic offer(input logic [4:0] op, input logic [TAG_W-1:0] tg, input logic rr);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, op, tg, 1'b0, rr, acc);
        if (!acc) check("offer_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_res_valid"}, res_valid, 1'b0);
        check({name, "_res_tag"}, res_tag, '0);
        check({name, "_res_data"}, res_data, '0);
        check({name, "_res_op"}, res_op, '0);
        check({name, "_fu_sel"}, fu_sel, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [4:0] ops_tab [9];
    logic       acc;
`ifdef FPU_SEQ_PERF_EN
    logic [31:0] stall0;
`endif

    initial begin
        ops_tab[0] = OP_FADD;  ops_tab[1] = OP_FSUB;  ops_tab[2] = OP_FMUL;
        ops_tab[3] = OP_FDIV;  ops_tab[4] = OP_FSQRT; ops_tab[5] = OP_FCVTS;
        ops_tab[6] = OP_FCVTW; ops_tab[7] = OP_FSGNJ; ops_tab[8] = 5'b00011;
        cyc = 0;
        model_clear();

        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        #2 rstn = 1'b1;

        // Single fadd: fu_sel four cycles after issue, result one cycle later.
        offer(OP_FADD, 5'd1, 1'b1);
        idle(7, 1'b1);

        // Long fdiv followed by a zero-latency op still retires in program order.
        offer(OP_FDIV, 5'd2, 1'b1);
        offer(OP_FSGNJ, 5'd3, 1'b1);
        idle(9, 1'b1);

        // fsqrt offered two cycles after fmul would land on fmul's completion slot.
`ifdef FPU_SEQ_PERF_EN
        stall0 = stall_cyc;
`endif
        offer(OP_FMUL, 5'd4, 1'b1);
        idle(1, 1'b1);
        offer(OP_FSQRT, 5'd5, 1'b1);
`ifdef FPU_SEQ_PERF_EN
        check("stall_cyc_delta", stall_cyc - stall0, 32'd1);
        check("busy_cyc_nonzero", 32'(busy_cyc != 0), 32'd1);
`endif
        idle(6, 1'b1);

        // Fill the queue with writeback stalled, then free one slot.
        for (int i = 0; i < DEPTH; i++) offer(5'(i + 1), 5'(8 + i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, OP_FSGNJ, 5'd20, 1'b0, 1'b0, acc);
        step(1'b1, OP_FSGNJ, 5'd20, 1'b0, 1'b1, acc);
        step(1'b1, OP_FSGNJ, 5'd20, 1'b0, 1'b0, acc);
        check("refill_accepted", acc, 1'b1);
        idle(8, 1'b1);

        // Flush with three ops in flight; an op offered alongside the flush is refused.
        offer(OP_FDIV, 5'd21, 1'b1);
        offer(OP_FMUL, 5'd22, 1'b1);
        offer(OP_FSQRT, 5'd23, 1'b1);
        step(1'b1, OP_FSGNJ, 5'd24, 1'b1, 1'b1, acc);
        idle(8, 1'b1);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), ops_tab[$urandom_range(0, 8)], 5'($urandom),
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0), acc);
        end
        idle(10, 1'b1);

        // Asynchronous reset while a result is waiting and an fdiv is pending.
        offer(OP_FSGNJ, 5'd7, 1'b0);
        offer(OP_FDIV, 5'd9, 1'b0);
        idle(2, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #3 rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
        cyc = 0;
        model_clear();
        offer(OP_FADD, 5'd11, 1'b1);
        idle(7, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
